seg_scan_ctrl: RTL and testbench

Time-multiplexed display scan controller that shares the single BCD-to-7-segment decoder between `NUM_DIGITS` display positions. It latches a packed BCD value through an update handshake and applies it only at frame boundaries, so no frame shows a mix of old and new digits. Each scan step presents one nibble and a one-hot digit select, then inserts an anti-ghosting blank gap. The block sits between the timer/counter core and the decoder/pad outputs.

---
 rtl/seg_pkg.sv | 20 ++
 rtl/seg_scan_ctrl_if.sv | 15 +
 rtl/seg_scan_presc.sv | 35 +++
 rtl/seg_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
//   scan_state_e : scan FSM states (IDLE / SHOW / GAP)
//   bcd_t        : one BCD nibble
//   BCD_W        : nibble width
//   BCD_MAX      : largest decodable BCD digit
package seg_pkg;

   localparam int unsigned BCD_W = 4;

   typedef logic [BCD_W-1:0] bcd_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SHOW = 2'd1,
      ST_GAP  = 2'd2
   } scan_state_e;

   localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Update handshake between the counter core and the scan controller.
//   value_i   : packed BCD value, nibble k drives digit k
//   upd_i     : update request, value_i sampled while high
//   upd_ack_o : one-cycle pulse when the pending value becomes active
// master = value producer, slave = scan controller.
interface seg_scan_ctrl_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] value_i;
   logic                    upd_i;
   logic                    upd_ack_o;

   modport master (output value_i, output upd_i, input  upd_ack_o);
   modport slave  (input  value_i, input  upd_i, output upd_ack_o);
endinterface

// File: rtl/seg_scan_presc.sv
// Digit-slot prescaler. Counts 0..SCAN_DIV-1 within one slot and flags
// the last SHOW cycle and the last GAP cycle of the slot.
//   clk, rst   : clock, async active-high reset
//   clr        : hold the count at zero (scanner idle or stopping)
//   show_end_c : last cycle of the SHOW part of the slot
//   gap_end_c  : last cycle of the slot
module seg_scan_presc #(
   parameter int unsigned SCAN_DIV  = 1024,
   parameter int unsigned BLANK_CYC = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic show_end_c,
   output logic gap_end_c
);
   localparam int unsigned PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned SHOW_LEN = SCAN_DIV - BLANK_CYC;

   logic [PW-1:0] cnt;

   // Slot counter, restarts at the end of every slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr || gap_end_c) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + PW'(1);
      end
   end

   assign show_end_c = (cnt == PW'(SHOW_LEN - 1));
   assign gap_end_c  = (cnt == PW'(SCAN_DIV - 1));
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller. Walks NUM_DIGITS digit slots,
// each SHOW (select + nibble) followed by a blank GAP. New values are taken
// through the update handshake and applied only at frame boundaries.
// Optional feature macro: SEG_SCAN_LZB_EN (leading-zero blanking).
//   clk, rst    : clock, async active-high reset
//   run_i       : scan enable, low forces IDLE
//   inv_i       : decoder polarity, registered to dec_inv_o
//   upd_if      : update handshake (value_i, upd_i, upd_ack_o)
//   bcd_o       : nibble to the decoder
//   dec_en_o    : decoder enable
//   dec_inv_o   : decoder invert
//   digit_sel_o : one-hot digit select, zero while blank
//   frame_o     : pulse on the last cycle of each frame
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned SCAN_DIV   = 1024,
   parameter int unsigned BLANK_CYC  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run_i,
   input  logic                  inv_i,
   seg_scan_ctrl_if.slave        upd_if,
   output bcd_t                  bcd_o,
   output logic                  dec_en_o,
   output logic                  dec_inv_o,
   output logic [NUM_DIGITS-1:0] digit_sel_o,
   output logic                  frame_o
);
   localparam int unsigned           IW       = $clog2(NUM_DIGITS);
   localparam int unsigned           VW       = BCD_W * NUM_DIGITS;
   localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] SEL_ONE  = NUM_DIGITS'(1);

   scan_state_e   state;
   logic [IW-1:0] idx;
   logic [VW-1:0] active;
   logic [VW-1:0] pending;
   logic          pend_flag;

   logic show_end_c;
   logic gap_end_c;
   logic suppress_c;
   bcd_t cur_nib_c;
   logic show_en_c;
   bcd_t nib [NUM_DIGITS];

   seg_scan_presc #(
      .SCAN_DIV  (SCAN_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) u_presc (
      .clk        (clk),
      .rst        (rst),
      .clr        ((state == ST_IDLE) || !run_i),
      .show_end_c (show_end_c),
      .gap_end_c  (gap_end_c)
   );

   // Unpacked view of the active value, one entry per digit.
   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_nib
      assign nib[k] = active[BCD_W*k +: BCD_W];
   end

`ifdef SEG_SCAN_LZB_EN
   // Highest non-zero digit of the active value; digit 0 is never above it.
   logic [IW-1:0] top_nz;
   always_comb begin
      top_nz = '0;
      for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
         if (nib[k] != '0) top_nz = IW'(k);
      end
   end
   assign suppress_c = (idx > top_nz);
`else
   assign suppress_c = 1'b0;
`endif

   assign cur_nib_c = nib[idx];
   assign show_en_c = (cur_nib_c <= BCD_MAX) && !suppress_c;

   // Scan FSM with registered outputs; outputs follow the state by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= ST_IDLE;
         idx              <= '0;
         active           <= '0;
         pending          <= '0;
         pend_flag        <= 1'b0;
         bcd_o            <= '0;
         dec_en_o         <= 1'b0;
         dec_inv_o        <= 1'b0;
         digit_sel_o      <= '0;
         frame_o          <= 1'b0;
         upd_if.upd_ack_o <= 1'b0;
      end else begin
         dec_inv_o        <= inv_i;
         frame_o          <= 1'b0;
         upd_if.upd_ack_o <= 1'b0;

         if (!run_i) begin
            state       <= ST_IDLE;
            idx         <= '0;
            bcd_o       <= '0;
            dec_en_o    <= 1'b0;
            digit_sel_o <= '0;
         end else begin
            unique case (state)
               ST_IDLE: begin
                  state       <= ST_SHOW;
                  idx         <= '0;
                  bcd_o       <= '0;
                  dec_en_o    <= 1'b0;
                  digit_sel_o <= '0;
               end
               ST_SHOW: begin
                  digit_sel_o <= SEL_ONE << idx;
                  bcd_o       <= cur_nib_c;
                  dec_en_o    <= show_en_c;
                  if (show_end_c) state <= ST_GAP;
               end
               ST_GAP: begin
                  // bcd_o deliberately holds the last shown nibble
                  digit_sel_o <= '0;
                  dec_en_o    <= 1'b0;
                  if (gap_end_c) begin
                     state <= ST_SHOW;
                     if (idx == IDX_LAST) begin
                        idx     <= '0;
                        frame_o <= 1'b1;
                        if (pend_flag) begin
                           active           <= pending;
                           pend_flag        <= 1'b0;
                           upd_if.upd_ack_o <= 1'b1;
                        end
                     end else begin
                        idx <= idx + IW'(1);
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end

         // A write in the commit cycle refills pending and keeps the flag set.
         if (upd_if.upd_i) begin
            pending   <= upd_if.value_i;
            pend_flag <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2).
// Reference model: position-in-frame counter with digit/slot derived arithmetically.
module tb_seg_scan_ctrl;
   localparam int unsigned ND    = 4;
   localparam int unsigned SD    = 8;
   localparam int unsigned BC    = 2;
   localparam int unsigned FRAME = ND * SD;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic       inv = 1'b0;
   logic [3:0] bcd;
   logic       en, dinv, frame;
   logic [3:0] sel;

   seg_scan_ctrl_if #(.NUM_DIGITS(ND)) u_if ();

   seg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
      .clk(clk), .rst(rst), .run_i(run), .inv_i(inv), .upd_if(u_if.slave),
      .bcd_o(bcd), .dec_en_o(en), .dec_inv_o(dinv), .digit_sel_o(sel), .frame_o(frame)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int n_cyc = 0;

   // model state
   bit          m_on;
   int          m_pos;
   logic [15:0] m_act, m_pend;
   bit          m_flag;
   logic [3:0]  e_bcd, e_sel;
   logic        e_en, e_inv, e_frame, e_ack;

   function automatic logic [3:0] nib_of(logic [15:0] v, int k);
      return 4'((v >> (4 * k)) & 16'h000F);
   endfunction

   // A digit is lit if it is a valid BCD digit and (with LZB) not a leading zero.
   function automatic logic digit_on(logic [15:0] v, int k);
      if (nib_of(v, k) > 4'd9) return 1'b0;
`ifdef SEG_SCAN_LZB_EN
      if (k == 0) return 1'b1;
      for (int j = k; j < int'(ND); j++) if (nib_of(v, j) != 4'd0) return 1'b1;
      return 1'b0;
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [11:0] dut_vec();
      return {u_if.upd_ack_o, frame, sel, dinv, en, bcd};
   endfunction

   function automatic logic [11:0] exp_vec();
      return {e_ack, e_frame, e_sel, e_inv, e_en, e_bcd};
   endfunction

   task automatic model_reset();
      m_on = 0; m_pos = 0; m_act = '0; m_pend = '0; m_flag = 0;
      e_bcd = '0; e_sel = '0; e_en = 0; e_inv = 0; e_frame = 0; e_ack = 0;
   endtask

   // Predict the outputs registered at the coming edge from the current inputs.
   task automatic model_step();
      int idx, off;
      e_inv = inv; e_frame = 0; e_ack = 0;
      if (!run) begin
         e_sel = '0; e_en = 0; e_bcd = '0; m_on = 0;
      end else if (!m_on) begin
         e_sel = '0; e_en = 0; e_bcd = '0; m_on = 1; m_pos = 0;
      end else begin
         idx = m_pos / int'(SD);
         off = m_pos % int'(SD);
         if (off < int'(SD - BC)) begin
            e_sel = 4'(1 << idx);
            e_bcd = nib_of(m_act, idx);
            e_en  = digit_on(m_act, idx);
         end else begin
            e_sel = '0; e_en = 0;
         end
         if (m_pos == int'(FRAME) - 1) begin
            e_frame = 1;
            if (m_flag) begin m_act = m_pend; m_flag = 0; e_ack = 1; end
         end
         m_pos = (m_pos + 1) % int'(FRAME);
      end
      if (u_if.upd_i) begin m_pend = u_if.value_i; m_flag = 1; end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      n_cyc++;
   endtask

   task automatic test_reset();
      rst = 1; run = 0; inv = 0; u_if.upd_i = 0; u_if.value_i = '0;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      n_cmp++;
      if (dut_vec() !== 12'h000) begin
         n_err++; $display("FAIL reset_vals dut=%h want=000", dut_vec());
      end
      rst = 0;
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
         n_err++; $display("FAIL reset_idle dut=%h want=%h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_basic_scan();
      int lat, last_f;
      u_if.upd_i = 1; u_if.value_i = 16'h1234;
      tick();
      u_if.upd_i = 0;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
         n_err++; $display("FAIL basic_upd dut=%h want=%h", dut_vec(), exp_vec());
      end
      run = 1; lat = 0;
      for (int i = 1; i <= 8 && lat == 0; i++) begin
         tick();
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_err++; $display("FAIL basic_start cyc=%0d dut=%h want=%h", n_cyc, dut_vec(), exp_vec());
         end
         if (sel[0]) lat = i;
      end
      n_cmp++;
      if (lat != 2) begin n_err++; $display("FAIL latency got=%0d want=2", lat); end
      last_f = -1;
      for (int i = 0; i < 3 * int'(FRAME); i++) begin
         tick();
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_err++; $display("FAIL basic_scan cyc=%0d dut=%h want=%h", n_cyc, dut_vec(), exp_vec());
         end
         if (frame) begin
            if (last_f >= 0) begin
               n_cmp++;
               if (n_cyc - last_f != int'(FRAME)) begin
                  n_err++; $display("FAIL frame_period got=%0d want=%0d", n_cyc - last_f, FRAME);
               end
            end
            last_f = n_cyc;
         end
      end
   endtask

   task automatic run_frames(input string tag, input int cycles, output int acks);
      acks = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_err++; $display("FAIL %s cyc=%0d dut=%h want=%h", tag, n_cyc, dut_vec(), exp_vec());
         end
         if (u_if.upd_ack_o) acks++;
      end
   endtask

   task automatic goto_pos(input int pos);
      for (int i = 0; i < 2 * int'(FRAME) && !(m_on && m_pos == pos); i++) begin
         tick();
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_err++; $display("FAIL goto cyc=%0d dut=%h want=%h", n_cyc, dut_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_update_midframe();
      int acks;
      goto_pos(10);
      u_if.upd_i = 1; u_if.value_i = 16'h5678;
      tick();
      u_if.upd_i = 0;
      run_frames("upd_mid", 2 * int'(FRAME), acks);
      n_cmp++;
      if (acks != 1) begin n_err++; $display("FAIL upd_mid_acks got=%0d want=1", acks); end
   endtask

   task automatic test_double_update();
      int acks, a2;
      logic [3:0] got;
      goto_pos(5);
      u_if.upd_i = 1; u_if.value_i = 16'h1111;
      tick();
      u_if.upd_i = 0;
      run_frames("dbl_a", 10, a2);
      u_if.upd_i = 1; u_if.value_i = 16'h2222;
      tick();
      u_if.upd_i = 0;
      run_frames("dbl_b", 2 * int'(FRAME), acks);
      n_cmp++;
      if (acks + a2 != 1) begin n_err++; $display("FAIL dbl_acks got=%0d want=1", acks + a2); end
      got = 4'hF;
      for (int i = 0; i < int'(FRAME) && got == 4'hF; i++) begin
         tick();
         if (sel == 4'b0001) got = bcd;
      end
      n_cmp++;
      if (got !== 4'h2) begin n_err++; $display("FAIL dbl_digit0 got=%h want=2", got); end
   endtask

   task automatic test_blanking();
      logic [15:0] vals [3];
      int acks;
      vals[0] = 16'h00A3; vals[1] = 16'h0A03; vals[2] = 16'h0005;
      foreach (vals[v]) begin
         u_if.upd_i = 1; u_if.value_i = vals[v];
         tick();
         u_if.upd_i = 0;
         run_frames("blank", 2 * int'(FRAME) + 3, acks);
      end
   endtask

   task automatic test_boundary_upd();
      int acks;
      u_if.upd_i = 1; u_if.value_i = 16'h4321;
      tick();
      u_if.upd_i = 0;
      goto_pos(int'(FRAME) - 1);
      u_if.upd_i = 1; u_if.value_i = 16'h9876;
      tick();
      u_if.upd_i = 0;
      n_cmp++;
      if (u_if.upd_ack_o !== 1'b1) begin n_err++; $display("FAIL bnd_ack1 got=%b want=1", u_if.upd_ack_o); end
      run_frames("bnd", 2 * int'(FRAME), acks);
      n_cmp++;
      if (acks != 1) begin n_err++; $display("FAIL bnd_acks got=%0d want=1", acks); end
   endtask

   task automatic test_run_drop();
      int acks, lat;
      run = 0;
      run_frames("drop_idle", 2, acks);
      run = 1;
      run_frames("drop_run", 13, acks);
      run = 0;
      tick();
      n_cmp++;
      if ({u_if.upd_ack_o, frame, sel, en, bcd} !== 11'h0) begin
         n_err++; $display("FAIL drop_idle_out dut=%h want=000", dut_vec());
      end
      run_frames("drop_hold", 3, acks);
      run = 1; lat = 0;
      for (int i = 1; i <= 8 && lat == 0; i++) begin
         tick();
         if (sel[0]) lat = i;
      end
      n_cmp++;
      if (lat != 2) begin n_err++; $display("FAIL restart_latency got=%0d want=2", lat); end
      run_frames("drop_resume", int'(FRAME), acks);
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         u_if.upd_i   = ($urandom_range(0, 15) == 0);
         u_if.value_i = 16'($urandom);
         inv          = 1'($urandom);
         run          = ($urandom_range(0, 99) != 0);
         tick();
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_err++; $display("FAIL random cyc=%0d dut=%h want=%h", n_cyc, dut_vec(), exp_vec());
         end
      end
      u_if.upd_i = 0; run = 1; inv = 0;
   endtask

   task automatic test_reset_midgap();
      int acks;
      u_if.upd_i = 1; u_if.value_i = 16'h7777;
      tick();
      u_if.upd_i = 0; inv = 1;
      for (int i = 0; i < 2 * int'(FRAME) && !(m_on && e_sel == 4'b0000 && e_frame == 0 && n_cyc > 2); i++)
         tick();
      rst = 1;
      #1;
      n_cmp++;
      if (dut_vec() !== 12'h000) begin
         n_err++; $display("FAIL reset_midgap dut=%h want=000", dut_vec());
      end
      model_reset();
      @(posedge clk);
      #1;
      rst = 0; inv = 0;
      run_frames("post_reset", 3 * int'(FRAME), acks);
      n_cmp++;
      if (acks != 0) begin n_err++; $display("FAIL post_reset_acks got=%0d want=0", acks); end
   endtask

   initial begin
      u_if.upd_i = 0;
      u_if.value_i = '0;
      model_reset();
      test_reset();
      test_basic_scan();
      test_update_midframe();
      test_double_update();
      test_blanking();
      test_boundary_upd();
      test_run_drop();
      test_random();
      test_reset_midgap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
